peripheral_uart_transmitter_param_wb: RTL
=========================================

// Module: peripheral_uart_transmitter_param_wb
// PURPOSE
//   Parametrised UART transmitter for the WishBone UART: DATA_W-bit TX FIFO plus framing FSM.
//   Serialises start/5..9 data bits LSB-first/optional parity/1,1.5,2 stop bits on stx_pad_o.
//   Sits between the WB register file (pushes THR writes) and the pad; one bit = OVERSAMPLE enable ticks.
// PARAMETERS
//   DATA_W      9   max word width (5..9); FIFO entry width
//   FIFO_DEPTH  16  TX FIFO entries, power of two >= 2
//   OVERSAMPLE  16  enable ticks per bit; even, >= 4
// PORTS
//   clk          in   1                      system clock
//   wb_rst_ni    in   1                      async reset, active low
//   enable       in   1                      baud oversample tick; FSM advances only when 1
//   tf_push      in   1                      push tx_dat_i into FIFO
//   tx_dat_i     in   DATA_W                 write data
//   tx_reset     in   1                      sync FIFO flush
//   lsr_mask     in   1                      clears tf_overrun
//   cfg_wlen     in   3                      word length = 5+cfg_wlen, clamped to DATA_W
//   cfg_stop2    in   1                      0: 1 stop; 1: 2 stop (1.5 if word length 5)
//   cfg_pe/cfg_ep/cfg_sp in 1 each           parity enable / even / stick
//   cfg_brk      in   1                      break: force stx_pad_o low
//   stx_pad_o    out  1                      serial out
//   tstate       out  3                      FSM state
//   tf_count     out  $clog2(FIFO_DEPTH)+1   FIFO occupancy
//   tf_full      out  1                      tf_count==FIFO_DEPTH
//   tf_overrun   out  1                      sticky: push while full
//   tx_idle      out  1                      tstate==IDLE && tf_count==0 (TEMT)
// BEHAVIOUR
//   Reset: tstate=IDLE, stx_q=1, FIFO empty, tf_overrun=0, tx_idle=1, counters 0.
//   stx_pad_o = cfg_brk ? 0 : stx_q; brk does not stall FSM. wb_rst_ni mid-frame -> line 1 at once.
//   FIFO: show-ahead head; push when full dropped and sets tf_overrun, even if pop same cycle.
//     Push+pop same cycle when not full: count unchanged. Pointers wrap mod FIFO_DEPTH.
//     tx_reset: count/pointers to 0 next cycle, beats push same cycle; frame in flight completes.
//     lsr_mask clears overrun; overrun set wins if both in same cycle.
//   FSM (all transitions on enable=1 cycles only):
//     IDLE(0): stx_q=1; tf_count!=0 -> POP.
//     POP(5): latch head into shift reg, tf_pop=1 for exactly one clk, parity=^data[wlen-1:0] -> START.
//     START(1): stx_q=0 for OVERSAMPLE ticks -> DATA.
//     DATA(2): stx_q=shift[0], each bit OVERSAMPLE ticks, shift right; after wlen bits -> PARITY if pe else STOP.
//     PARITY(3): sp=0: ep?parity:~parity; sp=1: ~ep. OVERSAMPLE ticks -> STOP.
//     STOP(4): stx_q=1 for OVERSAMPLE, 2*OVERSAMPLE, or 3*OVERSAMPLE/2 ticks -> IDLE.
//     Undefined code -> IDLE.
//   Config sampled at POP (wlen, pe, ep, sp) and STOP entry (stop2); changes mid-frame do not affect frame.
//   Latency, enable=1: push at cycle 0 -> count=1 cycle 1 -> POP cycle 2 -> stx low cycles 3..3+OVERSAMPLE-1.
//   Back-to-back: non-empty FIFO at STOP end -> IDLE one tick then POP; no extra idle bits.
//   Bit counter width $clog2(2*OVERSAMPLE)+1; bits beyond wlen ignored (upper bits of tx_dat_i).
// CONFIGURATION
//   UART_TX_CTS_EN defined: adds input cts_ni (1 bit, active-low clear-to-send, externally synchronised).
//     IDLE leaves only if tf_count!=0 && cts_ni==0; deassertion mid-frame never truncates frame.
//   Not defined: no cts_ni port; behaves as cts_ni==0 always.
// TESTING
//   OVERSAMPLE=16, enable=1, wlen=3, pe=0, push 0xA5 -> stx: low 16, bits 1,0,1,0,0,1,0,1 x16, high 16; tx_idle at end.
//   wlen=4, DATA_W=9, pe=1 ep=1, push 0x1FF -> 9 ones, parity 1; ep=0 -> parity 0; sp=1 ep=1 -> 0.
//   wlen=0, stop2=1 -> stop high 24 ticks; wlen=3 stop2=1 -> 32 ticks.
//   Push 17 words without pop (enable=0) -> tf_full, count 16, overrun=1; lsr_mask -> 0; tx_reset -> count 0.
//   tx_reset mid-frame with 3 queued -> current frame completes, then line idle, tx_idle=1.
//   UART_TX_CTS_EN: cts_ni=1 with 2 queued -> stays IDLE; cts_ni=0 -> frame; cts_ni=1 mid-frame -> frame completes.

Source files
------------

// File: rtl/peripheral_uart_transmitter_param_wb.sv
// UART transmitter: DATA_W-bit show-ahead TX FIFO feeding a start/data/parity/stop framing FSM.
// Optional hardware flow control is compiled in with `define UART_TX_CTS_EN (adds cts_ni).
module peripheral_uart_transmitter_param_wb #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                            clk,
    input  logic                            wb_rst_ni,
    input  logic                            enable,
    input  logic                            tf_push,
    input  logic [DATA_W-1:0]               tx_dat_i,
    input  logic                            tx_reset,
    input  logic                            lsr_mask,
    input  logic [2:0]                      cfg_wlen,
    input  logic                            cfg_stop2,
    input  logic                            cfg_pe,
    input  logic                            cfg_ep,
    input  logic                            cfg_sp,
    input  logic                            cfg_brk,
`ifdef UART_TX_CTS_EN
    input  logic                            cts_ni,
`endif
    output logic                            stx_pad_o,
    output logic [2:0]                      tstate,
    output logic [$clog2(FIFO_DEPTH):0]     tf_count,
    output logic                            tf_full,
    output logic                            tf_overrun,
    output logic                            tx_idle
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(2 * OVERSAMPLE) + 1;
    localparam logic [3:0]     DW4     = 4'(DATA_W);
    localparam logic [BCW-1:0] OS_LAST = BCW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_POP    = 3'd5
    } tx_state_e;

    tx_state_e         state;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;
    logic              tf_pop;
    logic              cts_ok;
    logic [DATA_W-1:0] head;

    logic [BCW-1:0]    tick_cnt;
    logic [BCW-1:0]    stop_last;
    logic [BCW-1:0]    stop_last_next;
    logic [3:0]        bit_idx;
    logic [3:0]        wlen_q;
    logic [3:0]        wlen_raw;
    logic [3:0]        wlen_eff;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] wmask;
    logic              data_par;
    logic              par_bit;
    logic              pe_q;
    logic              par_q;
    logic              stx_q;

`ifdef UART_TX_CTS_EN
    assign cts_ok = ~cts_ni;
`else
    assign cts_ok = 1'b1;
`endif

    assign head      = fifo_mem[rd_ptr];
    assign tf_full   = (tf_count == CW'(FIFO_DEPTH));
    assign tf_pop    = enable && (state == S_POP) && (tf_count != '0);
    assign push_ok   = tf_push && !tf_full && !tx_reset;
    assign pop_ok    = tf_pop && !tx_reset;
    assign tstate    = state;
    assign tx_idle   = (state == S_IDLE) && (tf_count == '0);
    assign stx_pad_o = cfg_brk ? 1'b0 : stx_q;

    // Word length and parity are computed from the head entry so they can be latched at POP.
    assign wlen_raw = {1'b0, cfg_wlen} + 4'd5;
    assign wlen_eff = (wlen_raw > DW4) ? DW4 : wlen_raw;
    assign wmask    = ~({DATA_W{1'b1}} << wlen_eff);
    assign data_par = ^(head & wmask);
    assign par_bit  = cfg_sp ? ~cfg_ep : (cfg_ep ? data_par : ~data_par);

    // Stop length: 1.5 bits only applies to 5-bit words, otherwise stop2 means 2 bits.
    assign stop_last_next = !cfg_stop2        ? OS_LAST :
                            (wlen_q == 4'd5)  ? BCW'(OVERSAMPLE * 3 / 2 - 1) :
                                                BCW'(2 * OVERSAMPLE - 1);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= tx_dat_i;
        end
    end

    // FIFO pointers and occupancy; a flush beats any push in the same cycle.
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tf_count <= '0;
        end else if (tx_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tf_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   tf_count <= tf_count + 1'b1;
                2'b01:   tf_count <= tf_count - 1'b1;
                default: tf_count <= tf_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tf_overrun <= 1'b0;
        end else if (tf_push && tf_full) begin
            tf_overrun <= 1'b1;
        end else if (lsr_mask) begin
            tf_overrun <= 1'b0;
        end
    end

    // Framing FSM; every transition and tick count happens only on enable cycles.
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= S_IDLE;
            stx_q     <= 1'b1;
            tick_cnt  <= '0;
            stop_last <= OS_LAST;
            bit_idx   <= '0;
            wlen_q    <= DW4;
            shift_q   <= '0;
            pe_q      <= 1'b0;
            par_q     <= 1'b0;
        end else if (enable) begin
            case (state)
                S_IDLE: begin
                    stx_q    <= 1'b1;
                    tick_cnt <= '0;
                    if ((tf_count != '0) && cts_ok) begin
                        state <= S_POP;
                    end
                end
                S_POP: begin
                    if (tf_count == '0) begin
                        state <= S_IDLE;
                    end else begin
                        shift_q  <= head;
                        wlen_q   <= wlen_eff;
                        pe_q     <= cfg_pe;
                        par_q    <= par_bit;
                        bit_idx  <= '0;
                        tick_cnt <= '0;
                        stx_q    <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (tick_cnt == OS_LAST) begin
                        tick_cnt <= '0;
                        stx_q    <= shift_q[0];
                        state    <= S_DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt == OS_LAST) begin
                        tick_cnt <= '0;
                        shift_q  <= shift_q >> 1;
                        if (bit_idx == (wlen_q - 4'd1)) begin
                            if (pe_q) begin
                                stx_q <= par_q;
                                state <= S_PARITY;
                            end else begin
                                stx_q     <= 1'b1;
                                stop_last <= stop_last_next;
                                state     <= S_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            stx_q   <= shift_q[1];
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tick_cnt == OS_LAST) begin
                        tick_cnt  <= '0;
                        stx_q     <= 1'b1;
                        stop_last <= stop_last_next;
                        state     <= S_STOP;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    stx_q <= 1'b1;
                    if (tick_cnt == stop_last) begin
                        tick_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    stx_q    <= 1'b1;
                    tick_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
